// File: rtl/mem_sched_pkg.sv
// Shared types for the memory-side weighted round-robin scheduler.
// Default sizing lives here; the top's parameters default to these values.
package mem_sched_pkg;

    localparam int MS_NUM_MASTER      = 4;
    localparam int MS_MAX_OUTSTANDING = 4;
    localparam int MS_WEIGHT_W        = 4;

    typedef logic [31:0] address_t;
    typedef logic [63:0] dcache_line_t;

    typedef enum logic {ARB, HOLD} sched_state_t;

    typedef logic [$clog2(MS_NUM_MASTER)-1:0] master_id_t;
    typedef logic [MS_WEIGHT_W-1:0]           weight_t;

endpackage

// File: rtl/mem_sched_arbiter_if.sv
// Requester-side and memory-side bus of the scheduler.
// slave = the arbiter's view; master = requesters plus memory controller.
interface mem_sched_arbiter_if import mem_sched_pkg::*; #(
    parameter int NUM_MASTER = MS_NUM_MASTER
) ();

    logic [NUM_MASTER-1:0] m_req_valid;
    logic [NUM_MASTER-1:0] m_req_write;
    address_t              m_req_address  [NUM_MASTER];
    dcache_line_t          m_req_data     [NUM_MASTER];
    logic [NUM_MASTER-1:0] m_req_ready;
    logic [NUM_MASTER-1:0] m_resp_valid;
    address_t              m_resp_address [NUM_MASTER];
    dcache_line_t          m_resp_data    [NUM_MASTER];

    logic                  s_req_read;
    logic                  s_req_write;
    address_t              s_req_address;
    dcache_line_t          s_req_data;
    logic                  s_req_available;
    logic                  s_resp_valid;
    address_t              s_resp_address;
    dcache_line_t          s_resp_data;

    modport slave (
        input  m_req_valid, m_req_write, m_req_address, m_req_data,
        input  s_req_available, s_resp_valid, s_resp_address, s_resp_data,
        output m_req_ready, m_resp_valid, m_resp_address, m_resp_data,
        output s_req_read, s_req_write, s_req_address, s_req_data
    );

    modport master (
        output m_req_valid, m_req_write, m_req_address, m_req_data,
        output s_req_available, s_resp_valid, s_resp_address, s_resp_data,
        input  m_req_ready, m_resp_valid, m_resp_address, m_resp_data,
        input  s_req_read, s_req_write, s_req_address, s_req_data
    );

endinterface

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO; SIZE must be a power of 2, at least 2.
// Read data is the registered head (0-cycle show-ahead); caller must not push when full.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int SIZE  = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_dat,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_pop_dat,
    output logic                   o_empty,
    output logic                   o_full,
    output logic [$clog2(SIZE):0]  o_count
);

    localparam int AW = $clog2(SIZE);

    logic [WIDTH-1:0] r_mem [SIZE];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (i_push && !i_pop)      r_count <= r_count + 1'b1;
            else if (!i_push && i_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_push_dat;
    end

    assign o_pop_dat = r_mem[r_rd_ptr];
    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(SIZE));
    assign o_count   = r_count;

endmodule

// File: rtl/mem_sched_arbiter.sv
// Weighted round-robin share of one memory port with in-order read tag routing; MEM_SCHED_PERF_CNT_EN adds grant counters.
// Latency: request and response both pass through combinationally (0 cycles).
// Backpressure: m_req_ready drops when memory is unavailable, reads stall when MAX_OUTSTANDING are in flight.
module mem_sched_arbiter import mem_sched_pkg::*; #(
    parameter int NUM_MASTER      = MS_NUM_MASTER,
    parameter int MAX_OUTSTANDING = MS_MAX_OUTSTANDING,
    parameter int WEIGHT_W        = MS_WEIGHT_W
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    mem_sched_arbiter_if.slave                 bus,
    input  logic [WEIGHT_W*NUM_MASTER-1:0]     i_cfg_weight,
    output logic [$clog2(MAX_OUTSTANDING):0]   o_outstanding_cnt,
    output logic                               o_err_orphan_resp,
    output logic [32*NUM_MASTER-1:0]           o_perf_grant_cnt
);

    sched_state_t          r_state;
    master_id_t            r_rr_ptr;
    master_id_t            r_owner;
    weight_t               r_credit;
    logic                  r_err_orphan;

    logic [NUM_MASTER-1:0] w_elig;
    logic                  w_found;
    master_id_t            w_winner;
    logic                  w_gnt_vld;
    master_id_t            w_gnt_id;
    weight_t               w_wt;
    weight_t               w_credit_init;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_empty;
    logic                  w_full;
    master_id_t            w_head;

    // Read slots come from the registered count only; a same-cycle pop frees nothing yet.
    assign w_elig = {NUM_MASTER{i_rst_n & bus.s_req_available}} & bus.m_req_valid
                  & (bus.m_req_write | {NUM_MASTER{~w_full}});

    always_comb begin
        master_id_t idx;
        idx      = r_rr_ptr;
        w_found  = 1'b0;
        w_winner = r_rr_ptr;
        for (int k = 0; k < NUM_MASTER; k++) begin
            idx = r_rr_ptr + master_id_t'(k);
            if (!w_found && w_elig[idx]) begin
                w_found  = 1'b1;
                w_winner = idx;
            end
        end
    end

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = r_owner;
        if (r_state == ARB) begin
            w_gnt_vld = w_found;
            if (w_found) w_gnt_id = w_winner;
        end else begin
            w_gnt_vld = w_elig[r_owner];
        end
    end

    assign w_wt          = i_cfg_weight[int'(w_gnt_id)*WEIGHT_W +: WEIGHT_W];
    assign w_credit_init = (w_wt == '0) ? '0 : w_wt - 1'b1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ARB;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_credit <= '0;
        end else begin
            case (r_state)
                ARB: begin
                    if (w_found) begin
                        r_owner  <= w_winner;
                        r_rr_ptr <= w_winner + 1'b1;
                        r_credit <= w_credit_init;
                        r_state  <= (w_credit_init != '0) ? HOLD : ARB;
                    end
                end
                HOLD: begin
                    // Owner walking away forfeits whatever quantum it had left.
                    if (!bus.m_req_valid[r_owner]) begin
                        r_state  <= ARB;
                        r_credit <= '0;
                    end else if (w_gnt_vld) begin
                        r_credit <= r_credit - 1'b1;
                        if (r_credit == weight_t'(1)) r_state <= ARB;
                    end
                end
                default: r_state <= ARB;
            endcase
        end
    end

    always_comb begin
        bus.m_req_ready = '0;
        if (w_gnt_vld) bus.m_req_ready[w_gnt_id] = 1'b1;
    end

    assign bus.s_req_read    = w_gnt_vld & ~bus.m_req_write[w_gnt_id];
    assign bus.s_req_write   = w_gnt_vld &  bus.m_req_write[w_gnt_id];
    assign bus.s_req_address = bus.m_req_address[w_gnt_id];
    assign bus.s_req_data    = bus.m_req_data[w_gnt_id];

    assign w_push = bus.s_req_read;
    assign w_pop  = bus.s_resp_valid & ~w_empty;

    sync_fifo #(
        .WIDTH ($bits(master_id_t)),
        .SIZE  (MAX_OUTSTANDING)
    ) u_tag_q (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_push     (w_push),
        .i_push_dat (w_gnt_id),
        .i_pop      (w_pop),
        .o_pop_dat  (w_head),
        .o_empty    (w_empty),
        .o_full     (w_full),
        .o_count    (o_outstanding_cnt)
    );

    always_comb begin
        bus.m_resp_valid = '0;
        if (w_pop) bus.m_resp_valid[w_head] = 1'b1;
        for (int i = 0; i < NUM_MASTER; i++) begin
            bus.m_resp_address[i] = bus.s_resp_address;
            bus.m_resp_data[i]    = bus.s_resp_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                         r_err_orphan <= 1'b0;
        else if (bus.s_resp_valid && w_empty) r_err_orphan <= 1'b1;
    end

    assign o_err_orphan_resp = r_err_orphan;

`ifdef MEM_SCHED_PERF_CNT_EN
    logic [31:0] r_perf_cnt [NUM_MASTER];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_MASTER; i++) r_perf_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_MASTER; i++) begin
                if (w_gnt_vld && w_gnt_id == master_id_t'(i) && r_perf_cnt[i] != 32'hFFFF_FFFF)
                    r_perf_cnt[i] <= r_perf_cnt[i] + 32'd1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_MASTER; i++) o_perf_grant_cnt[32*i +: 32] = r_perf_cnt[i];
    end
`else
    assign o_perf_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_sched_arbiter.sv
// Bench for mem_sched_arbiter: grant-order table, read tag routing scoreboard, orphan and reset corners.
// Inputs change 1ns after the rising edge; outputs are sampled a few ns later.
module tb_mem_sched_arbiter;
    import mem_sched_pkg::*;

    logic         i_clk = 1'b0;
    logic         i_rst_n;
    logic [15:0]  cfg_weight;
    logic [2:0]   outstanding_cnt;
    logic         err_orphan;
    logic [127:0] perf_cnt;

    int n_chk = 0;
    int n_err = 0;
    int sb[$];

    typedef struct {
        logic [3:0] v;
        logic [3:0] w;
        logic       av;
        logic [3:0] rdy;
    } vec_t;
    vec_t tbl [13];

    always #5 i_clk = ~i_clk;

    mem_sched_arbiter_if bus ();

    mem_sched_arbiter dut (
        .i_clk             (i_clk),
        .i_rst_n           (i_rst_n),
        .bus               (bus),
        .i_cfg_weight      (cfg_weight),
        .o_outstanding_cnt (outstanding_cnt),
        .o_err_orphan_resp (err_orphan),
        .o_perf_grant_cnt  (perf_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_req(input logic [3:0] v, input logic [3:0] w, input logic av);
        bus.m_req_valid     = v;
        bus.m_req_write     = w;
        bus.s_req_available = av;
    endtask

    // Drive one in-order memory response and check it lands on the scoreboard's head master.
    task automatic resp(input logic [63:0] d);
        int         e;
        logic [3:0] oh;
        bus.s_resp_valid   = 1'b1;
        bus.s_resp_data    = d;
        bus.s_resp_address = d[31:0];
        #2;
        if (sb.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL resp_scoreboard_empty actual=%0h required=none", bus.m_resp_valid);
        end else begin
            e  = sb.pop_front();
            oh = 4'b0001 << e;
            chk("resp_route", bus.m_resp_valid, oh);
            chk("resp_data", bus.m_resp_data[e], d);
            chk("resp_addr", bus.m_resp_address[e], d[31:0]);
        end
        step();
        bus.s_resp_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n    = 1'b0;
        cfg_weight = {4'd1, 4'd1, 4'd1, 4'd2};
        set_req(4'hF, 4'hF, 1'b1);
        bus.s_resp_valid   = 1'b0;
        bus.s_resp_address = '0;
        bus.s_resp_data    = '0;
        for (int i = 0; i < 4; i++) begin
            bus.m_req_address[i] = 32'(32'h100 + i);
            bus.m_req_data[i]    = 64'(64'hD0 + i);
        end

        // Master 0 weight 2, others 1.
        tbl[0]  = '{4'hF, 4'hF, 1'b1, 4'b0001};
        tbl[1]  = '{4'hF, 4'hF, 1'b1, 4'b0001};
        tbl[2]  = '{4'hF, 4'hF, 1'b1, 4'b0010};
        tbl[3]  = '{4'hF, 4'hF, 1'b1, 4'b0100};
        tbl[4]  = '{4'hF, 4'hF, 1'b1, 4'b1000};
        tbl[5]  = '{4'hF, 4'hF, 1'b1, 4'b0001};
        tbl[6]  = '{4'hF, 4'hF, 1'b1, 4'b0001};
        tbl[7]  = '{4'hF, 4'hF, 1'b1, 4'b0010};
        tbl[8]  = '{4'hF, 4'hF, 1'b0, 4'b0000};
        tbl[9]  = '{4'hF, 4'hF, 1'b1, 4'b0100};
        tbl[10] = '{4'h1, 4'hF, 1'b1, 4'b0001};
        tbl[11] = '{4'hE, 4'hF, 1'b1, 4'b0000};
        tbl[12] = '{4'hE, 4'hF, 1'b1, 4'b0010};

        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_ready", bus.m_req_ready, 4'b0);
        chk("rst_swrite", bus.s_req_write, 1'b0);
        chk("rst_sread", bus.s_req_read, 1'b0);
        chk("rst_cnt", outstanding_cnt, 3'd0);
        chk("rst_err", err_orphan, 1'b0);
        i_rst_n = 1'b1;

        for (int k = 0; k < 13; k++) begin
            set_req(tbl[k].v, tbl[k].w, tbl[k].av);
            #2;
            chk($sformatf("tbl%0d_ready", k), bus.m_req_ready, tbl[k].rdy);
            chk($sformatf("tbl%0d_swrite", k), bus.s_req_write, |tbl[k].rdy);
            if (tbl[k].rdy != 4'b0)
                chk($sformatf("tbl%0d_addr", k), bus.s_req_address, 32'(32'h100 + $clog2(tbl[k].rdy)));
            step();
        end

        // Master 2 fills the tag queue.
        set_req(4'b0100, 4'b0000, 1'b1);
        for (int k = 0; k < 4; k++) begin
            #2;
            chk("rd_acc", bus.m_req_ready, 4'b0100);
            chk("rd_sread", bus.s_req_read, 1'b1);
            sb.push_back(2);
            step();
        end
        #2;
        chk("rd_cnt_full", outstanding_cnt, 3'd4);
        chk("rd_5th_blocked", bus.m_req_ready, 4'b0);
        bus.s_resp_valid = 1'b1;
        bus.s_resp_data  = 64'hA5A5;
        #1;
        chk("rd_same_cycle_blocked", bus.m_req_ready, 4'b0);
        chk("rd_same_cycle_resp", bus.m_resp_valid, 4'b0100);
        void'(sb.pop_front());
        step();
        bus.s_resp_valid = 1'b0;
        #2;
        chk("rd_5th_acc", bus.m_req_ready, 4'b0100);
        sb.push_back(2);
        step();
        set_req(4'b0, 4'b0, 1'b1);
        #2;
        chk("rd_cnt_refill", outstanding_cnt, 3'd4);
        for (int k = 0; k < 4; k++) resp(64'(64'h1000 + k));
        #2;
        chk("rd_cnt_drained", outstanding_cnt, 3'd0);

        // Routing: master 1 read then master 3 read, responses in order.
        set_req(4'b0010, 4'b0, 1'b1);
        #2;
        chk("route_m1_acc", bus.m_req_ready, 4'b0010);
        sb.push_back(1);
        step();
        set_req(4'b1000, 4'b0, 1'b1);
        #2;
        chk("route_m3_acc", bus.m_req_ready, 4'b1000);
        sb.push_back(3);
        step();
        set_req(4'b0, 4'b0, 1'b1);
        resp(64'hAAAA_0001);
        resp(64'hBBBB_0003);

        // Orphan response with an empty queue.
        bus.s_resp_valid = 1'b1;
        #2;
        chk("orphan_no_resp", bus.m_resp_valid, 4'b0);
        chk("orphan_err_pre", err_orphan, 1'b0);
        step();
        bus.s_resp_valid = 1'b0;
        #2;
        chk("orphan_err_set", err_orphan, 1'b1);
        repeat (3) step();
        chk("orphan_err_held", err_orphan, 1'b1);

        // Reset with three reads in flight.
        set_req(4'b0001, 4'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("mid_rd_acc", bus.m_req_ready, 4'b0001);
            step();
        end
        set_req(4'b0, 4'b0, 1'b1);
        #2;
        chk("mid_cnt3", outstanding_cnt, 3'd3);
        i_rst_n = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_cnt", outstanding_cnt, 3'd0);
        chk("mid_rst_err", err_orphan, 1'b0);
        step();
        i_rst_n = 1'b1;
        bus.s_resp_valid = 1'b1;
        #2;
        chk("mid_late_resp_dropped", bus.m_resp_valid, 4'b0);
        step();
        bus.s_resp_valid = 1'b0;
        #2;
        chk("mid_late_resp_orphan", err_orphan, 1'b1);
        step();

        // Ten write grants to master 0.
        set_req(4'b0001, 4'b0001, 1'b1);
        for (int k = 0; k < 10; k++) begin
            #2;
            chk("perf_grant", bus.m_req_ready, 4'b0001);
            step();
        end
        set_req(4'b0, 4'b0, 1'b1);
        #2;
`ifdef MEM_SCHED_PERF_CNT_EN
        chk("perf_m0", perf_cnt[31:0], 64'd10);
        chk("perf_m1", perf_cnt[63:32], 64'd0);
`else
        chk("perf_tied_low", perf_cnt[63:0], 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
